// File: rtl/axi4_if.sv
// AXI4-lite channel bundle (with ids and rlast) shared by the error responder
// and whatever drives it. One agent per modport.
//
// Handshake rule on every channel: a transfer happens on the rising aclk edge
// where valid and ready are both high. A source keeps valid and its payload
// stable until that edge, and ready may depend only on the sink's registered
// state.
interface axi4_if #(
  parameter int A = 32,
  parameter int N = 4,
  parameter int I = 1
);
  logic           awvalid;
  logic           awready;
  logic [A-1:0]   awaddr;
  logic [I-1:0]   awid;
  logic           wvalid;
  logic           wready;
  logic [8*N-1:0] wdata;
  logic [N-1:0]   wstrb;
  logic           bvalid;
  logic           bready;
  logic [I-1:0]   bid;
  logic [1:0]     bresp;
  logic           arvalid;
  logic           arready;
  logic [A-1:0]   araddr;
  logic [I-1:0]   arid;
  logic           rvalid;
  logic           rready;
  logic [I-1:0]   rid;
  logic [8*N-1:0] rdata;
  logic [1:0]     rresp;
  logic           rlast;

  modport master (
    output awvalid, awaddr, awid, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arid, rready,
    input  awready, wready, bvalid, bid, bresp,
           arready, rvalid, rid, rdata, rresp, rlast
  );

  modport slave (
    input  awvalid, awaddr, awid, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arid, rready,
    output awready, wready, bvalid, bid, bresp,
           arready, rvalid, rid, rdata, rresp, rlast
  );
endinterface

// File: rtl/axi4_lite_error_slave.sv
// Default/error responder for unmapped AXI4-lite space. Every transaction is
// answered with RESP, and reads return the fixed pattern D. AW and W are
// accepted independently. Up to DEPTH transactions per direction are queued.
// It also keeps saturating response counters and the last offending address.
module axi4_lite_error_slave #(
  parameter int          A     = 32,
  parameter int          N     = 4,
  parameter int          I     = 1,
  parameter logic [63:0] D     = 64'hbaadc0de,
  parameter logic [1:0]  RESP  = 2'b11,
  parameter int          DEPTH = 2,
  parameter int          CW    = 16
) (
  input  logic          aclk,
  input  logic          aresetn,
  axi4_if.slave         axi4_s,
  output logic [CW-1:0] wr_err_count,
  output logic [CW-1:0] rd_err_count,
  output logic [A-1:0]  last_err_addr,
  output logic          last_err_write,
  output logic          err_pulse
);
  localparam int              DW    = 8 * N;
  localparam int              PW    = $clog2(DEPTH);
  localparam int              CNTW  = $clog2(DEPTH + 1);
  localparam logic [CNTW-1:0] FULL  = CNTW'(DEPTH);
  localparam logic [DW-1:0]   RDATA = DW'(D);

  // write-address id queue, W credit counter, read id queue
  logic [I-1:0]    aw_id_q [DEPTH];
  logic [I-1:0]    aw_id_d [DEPTH];
  logic [PW-1:0]   aw_wp_q, aw_wp_d, aw_rp_q, aw_rp_d;
  logic [CNTW-1:0] aw_cnt_q, aw_cnt_d;
  logic [CNTW-1:0] w_cnt_q, w_cnt_d;
  logic [I-1:0]    ar_id_q [DEPTH];
  logic [I-1:0]    ar_id_d [DEPTH];
  logic [PW-1:0]   ar_wp_q, ar_wp_d, ar_rp_q, ar_rp_d;
  logic [CNTW-1:0] ar_cnt_q, ar_cnt_d;

  // debug/CSR state
  logic [CW-1:0]   wr_err_count_q, wr_err_count_d;
  logic [CW-1:0]   rd_err_count_q, rd_err_count_d;
  logic [A-1:0]    last_err_addr_q, last_err_addr_d;
  logic            last_err_write_q, last_err_write_d;
  logic            err_pulse_q, err_pulse_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  // Write payload carries no information for a decode hole.
  logic unused_wpayload;
  assign unused_wpayload = ^{axi4_s.wdata, axi4_s.wstrb};

  // Readies come from registered occupancy only. They are held low while reset is applied.
  assign axi4_s.awready = aresetn & (aw_cnt_q != FULL);
  assign axi4_s.wready  = aresetn & (w_cnt_q != FULL);
  assign axi4_s.arready = aresetn & (ar_cnt_q != FULL);

  // A B response needs both a queued address and a banked data beat.
  assign axi4_s.bvalid = (aw_cnt_q != '0) & (w_cnt_q != '0);
  assign axi4_s.bid    = aw_id_q[aw_rp_q];
  assign axi4_s.bresp  = RESP;
  assign axi4_s.rvalid = (ar_cnt_q != '0);
  assign axi4_s.rid    = ar_id_q[ar_rp_q];
  assign axi4_s.rdata  = RDATA;
  assign axi4_s.rresp  = RESP;
  assign axi4_s.rlast  = 1'b1;

  assign aw_hs = axi4_s.awvalid & axi4_s.awready;
  assign w_hs  = axi4_s.wvalid & axi4_s.wready;
  assign b_hs  = axi4_s.bvalid & axi4_s.bready;
  assign ar_hs = axi4_s.arvalid & axi4_s.arready;
  assign r_hs  = axi4_s.rvalid & axi4_s.rready;

  assign wr_err_count   = wr_err_count_q;
  assign rd_err_count   = rd_err_count_q;
  assign last_err_addr  = last_err_addr_q;
  assign last_err_write = last_err_write_q;
  assign err_pulse      = err_pulse_q;

  // Next state for the write path: AW queue push/pop and W credit accounting.
  always_comb begin
    aw_id_d  = aw_id_q;
    aw_wp_d  = aw_wp_q;
    aw_rp_d  = aw_rp_q;
    aw_cnt_d = aw_cnt_q;
    w_cnt_d  = w_cnt_q;
    if (aw_hs) begin
      aw_id_d[aw_wp_q] = axi4_s.awid;
      aw_wp_d          = aw_wp_q + 1'b1;
    end
    if (b_hs) aw_rp_d = aw_rp_q + 1'b1;
    case ({aw_hs, b_hs})
      2'b10:   aw_cnt_d = aw_cnt_q + 1'b1;
      2'b01:   aw_cnt_d = aw_cnt_q - 1'b1;
      default: aw_cnt_d = aw_cnt_q;
    endcase
    case ({w_hs, b_hs})
      2'b10:   w_cnt_d = w_cnt_q + 1'b1;
      2'b01:   w_cnt_d = w_cnt_q - 1'b1;
      default: w_cnt_d = w_cnt_q;
    endcase
  end

  // Next state for the read path: AR id queue push/pop.
  always_comb begin
    ar_id_d  = ar_id_q;
    ar_wp_d  = ar_wp_q;
    ar_rp_d  = ar_rp_q;
    ar_cnt_d = ar_cnt_q;
    if (ar_hs) begin
      ar_id_d[ar_wp_q] = axi4_s.arid;
      ar_wp_d          = ar_wp_q + 1'b1;
    end
    if (r_hs) ar_rp_d = ar_rp_q + 1'b1;
    case ({ar_hs, r_hs})
      2'b10:   ar_cnt_d = ar_cnt_q + 1'b1;
      2'b01:   ar_cnt_d = ar_cnt_q - 1'b1;
      default: ar_cnt_d = ar_cnt_q;
    endcase
  end

  // Next state for debug outputs. AW wins over AR when both are accepted together.
  always_comb begin
    wr_err_count_d   = wr_err_count_q;
    rd_err_count_d   = rd_err_count_q;
    last_err_addr_d  = last_err_addr_q;
    last_err_write_d = last_err_write_q;
    err_pulse_d      = aw_hs | ar_hs;
    if (b_hs && (wr_err_count_q != '1)) wr_err_count_d = wr_err_count_q + 1'b1;
    if (r_hs && (rd_err_count_q != '1)) rd_err_count_d = rd_err_count_q + 1'b1;
    if (aw_hs) begin
      last_err_addr_d  = axi4_s.awaddr;
      last_err_write_d = 1'b1;
    end else if (ar_hs) begin
      last_err_addr_d  = axi4_s.araddr;
      last_err_write_d = 1'b0;
    end
  end

  // Register all state. Reset empties both queues and drops anything in flight.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        aw_id_q[i] <= '0;
        ar_id_q[i] <= '0;
      end
      aw_wp_q          <= '0;
      aw_rp_q          <= '0;
      aw_cnt_q         <= '0;
      w_cnt_q          <= '0;
      ar_wp_q          <= '0;
      ar_rp_q          <= '0;
      ar_cnt_q         <= '0;
      wr_err_count_q   <= '0;
      rd_err_count_q   <= '0;
      last_err_addr_q  <= '0;
      last_err_write_q <= 1'b0;
      err_pulse_q      <= 1'b0;
    end else begin
      aw_id_q          <= aw_id_d;
      ar_id_q          <= ar_id_d;
      aw_wp_q          <= aw_wp_d;
      aw_rp_q          <= aw_rp_d;
      aw_cnt_q         <= aw_cnt_d;
      w_cnt_q          <= w_cnt_d;
      ar_wp_q          <= ar_wp_d;
      ar_rp_q          <= ar_rp_d;
      ar_cnt_q         <= ar_cnt_d;
      wr_err_count_q   <= wr_err_count_d;
      rd_err_count_q   <= rd_err_count_d;
      last_err_addr_q  <= last_err_addr_d;
      last_err_write_q <= last_err_write_d;
      err_pulse_q      <= err_pulse_d;
    end
  end
endmodule

// File: tb/tb_axi4_lite_error_slave.sv
// Randomized bench for axi4_lite_error_slave. The driver issues AW/W/AR traffic
// and pushes the expected response ids. The monitor checks every cycle against
// a queue-based model of the responder.
module tb_axi4_lite_error_slave;
  localparam int          A     = 32;
  localparam int          N     = 4;
  localparam int          I     = 2;
  localparam int          DEPTH = 2;
  localparam int          CW    = 3;
  localparam logic [63:0] D     = 64'hbaadc0de;
  localparam logic [1:0]  RESP  = 2'b11;
  localparam logic [31:0] EXP_RDATA = 32'hbaadc0de;
  localparam int          SAT   = (1 << CW) - 1;

  // clock / reset
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axi4_if #(.A(A), .N(N), .I(I)) bus ();

  logic [CW-1:0] wr_err_count, rd_err_count;
  logic [A-1:0]  last_err_addr;
  logic          last_err_write, err_pulse;

  axi4_lite_error_slave #(
    .A(A), .N(N), .I(I), .D(D), .RESP(RESP), .DEPTH(DEPTH), .CW(CW)
  ) u_dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .axi4_s         (bus),
    .wr_err_count   (wr_err_count),
    .rd_err_count   (rd_err_count),
    .last_err_addr  (last_err_addr),
    .last_err_write (last_err_write),
    .err_pulse      (err_pulse)
  );

  // scoreboard
  logic [I-1:0] exp_b_q[$];
  logic [I-1:0] exp_r_q[$];
  int           w_credits = 0;
  int           tests = 0;
  int           failed = 0;
  bit           mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: compare outputs to the model, then advance the model by this cycle
  initial begin : monitor
    int           exp_wr, exp_rd;
    logic [A-1:0] exp_addr;
    bit           exp_write, exp_pulse;
    bit           m_awr, m_wr, m_arr, m_bv, m_rv, aw_hs, ar_hs;
    exp_wr = 0; exp_rd = 0; exp_addr = '0; exp_write = 0; exp_pulse = 0;
    forever begin
      @(negedge aclk);
      #1;
      if (mon_en) begin
        check("wr_err_count", 64'(wr_err_count), 64'(exp_wr));
        check("rd_err_count", 64'(rd_err_count), 64'(exp_rd));
        check("last_err_addr", 64'(last_err_addr), 64'(exp_addr));
        check("last_err_write", 64'(last_err_write), 64'(exp_write));
        check("err_pulse", 64'(err_pulse), 64'(exp_pulse));
        if (!aresetn) begin
          check("awready_in_reset", 64'(bus.awready), 64'd0);
          check("wready_in_reset", 64'(bus.wready), 64'd0);
          check("arready_in_reset", 64'(bus.arready), 64'd0);
          exp_b_q.delete();
          exp_r_q.delete();
          w_credits = 0;
          exp_wr = 0; exp_rd = 0; exp_addr = '0; exp_write = 0; exp_pulse = 0;
        end else begin
          m_awr = exp_b_q.size() < DEPTH;
          m_wr  = w_credits < DEPTH;
          m_arr = exp_r_q.size() < DEPTH;
          m_bv  = (exp_b_q.size() > 0) && (w_credits > 0);
          m_rv  = exp_r_q.size() > 0;
          check("awready", 64'(bus.awready), 64'(m_awr));
          check("wready", 64'(bus.wready), 64'(m_wr));
          check("arready", 64'(bus.arready), 64'(m_arr));
          check("bvalid", 64'(bus.bvalid), 64'(m_bv));
          check("rvalid", 64'(bus.rvalid), 64'(m_rv));
          if (m_bv && bus.bready) begin
            check("bid", 64'(bus.bid), 64'(exp_b_q[0]));
            check("bresp", 64'(bus.bresp), 64'(RESP));
            void'(exp_b_q.pop_front());
            w_credits--;
            exp_wr = (exp_wr < SAT) ? exp_wr + 1 : SAT;
          end
          if (m_rv && bus.rready) begin
            check("rid", 64'(bus.rid), 64'(exp_r_q[0]));
            check("rdata", 64'(bus.rdata), 64'(EXP_RDATA));
            check("rresp", 64'(bus.rresp), 64'(RESP));
            check("rlast", 64'(bus.rlast), 64'd1);
            void'(exp_r_q.pop_front());
            exp_rd = (exp_rd < SAT) ? exp_rd + 1 : SAT;
          end
          aw_hs = bus.awvalid && m_awr;
          ar_hs = bus.arvalid && m_arr;
          exp_pulse = aw_hs || ar_hs;
          if (aw_hs) begin
            exp_addr  = bus.awaddr;
            exp_write = 1'b1;
          end else if (ar_hs) begin
            exp_addr  = bus.araddr;
            exp_write = 1'b0;
          end
        end
      end
    end
  end

  // driver state: a valid stays up with stable payload until accepted
  bit aw_acc = 1'b1, w_acc = 1'b1, ar_acc = 1'b1;

  task automatic drive_cycle(input int p_aw, input int p_w, input int p_ar,
                             input int p_b, input int p_r, input int p_rst);
    aresetn = ($urandom_range(0, 999) < p_rst) ? 1'b0 : 1'b1;
    if (!bus.awvalid || aw_acc) begin
      bus.awvalid = ($urandom_range(0, 99) < p_aw);
      bus.awid    = I'($urandom_range(0, (1 << I) - 1));
      bus.awaddr  = ($urandom_range(0, 3) == 0) ? 32'h0000_0100 : $urandom;
    end
    if (!bus.wvalid || w_acc) begin
      bus.wvalid = ($urandom_range(0, 99) < p_w);
      bus.wdata  = $urandom;
      bus.wstrb  = N'($urandom_range(0, 15));
    end
    if (!bus.arvalid || ar_acc) begin
      bus.arvalid = ($urandom_range(0, 99) < p_ar);
      bus.arid    = I'($urandom_range(0, (1 << I) - 1));
      bus.araddr  = ($urandom_range(0, 3) == 0) ? 32'h4000_0010 : $urandom;
    end
    bus.bready = ($urandom_range(0, 99) < p_b);
    bus.rready = ($urandom_range(0, 99) < p_r);
  endtask

  task automatic record_cycle();
    if (aresetn) begin
      aw_acc = bus.awvalid && bus.awready;
      w_acc  = bus.wvalid && bus.wready;
      ar_acc = bus.arvalid && bus.arready;
      if (aw_acc) exp_b_q.push_back(bus.awid);
      if (w_acc)  w_credits++;
      if (ar_acc) exp_r_q.push_back(bus.arid);
    end else begin
      aw_acc = 1'b1;
      w_acc  = 1'b1;
      ar_acc = 1'b1;
    end
  endtask

  // stimulus phases: streaming, backpressure, W-ahead-of-AW, random with resets
  initial begin : driver
    int p_aw[4]  = '{80, 70, 30, 60};
    int p_w[4]   = '{80, 70, 90, 60};
    int p_ar[4]  = '{80, 70, 60, 60};
    int p_b[4]   = '{100, 15, 60, 50};
    int p_r[4]   = '{100, 15, 60, 50};
    int p_rst[4] = '{0, 0, 3, 20};
    bus.awvalid = 0; bus.awid = '0; bus.awaddr = '0;
    bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0;
    bus.arvalid = 0; bus.arid = '0; bus.araddr = '0;
    bus.bready = 0; bus.rready = 0;
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    mon_en = 1'b1;
    for (int ph = 0; ph < 4; ph++) begin
      for (int cyc = 0; cyc < 500; cyc++) begin
        @(negedge aclk);
        drive_cycle(p_aw[ph], p_w[ph], p_ar[ph], p_b[ph], p_r[ph], p_rst[ph]);
        #2;
        record_cycle();
      end
    end
    // quiet tail lets queued responses drain under open readies
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge aclk);
      aresetn = 1'b1;
      bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
      bus.bready = 1; bus.rready = 1;
      #2;
      record_cycle();
    end
    @(negedge aclk);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/axi4_lite_error_slave.md
Name: axi4_lite_error_slave

Overview:
Parametrised default/error responder for AXI4-lite interconnect decode holes. It terminates every transaction addressed to unmapped space with a configurable response code and read pattern. Unlike a single-shot responder, it accepts AW and W independently and queues up to DEPTH outstanding transactions per direction. It also exposes saturating error counters and the last offending address for debug/CSR readback.

Parameters:
A, 32, address width in bits
N, 4, data bus width in bytes (rdata width 8*N)
I, 1, ID width for awid/bid/arid/rid
D, 'hbaadc0de, read data pattern, zero-extended or truncated to 8*N
RESP, 2'b11, bresp/rresp value (2'b11 DECERR, 2'b10 SLVERR, 2'b00 OKAY)
DEPTH, 2, outstanding queue depth per channel; power of 2, >=2
CW, 16, error counter width

Ports:
aclk  input  1  clock
aresetn  input  1  reset, synchronous, active-low
axi4_s  interface  axi4_if slave  AXI4-lite slave port (aw/w/b/ar/r channels, ids, rlast)
wr_err_count  output  CW  number of completed write responses (B handshakes), saturating
rd_err_count  output  CW  number of completed read responses (R handshakes), saturating
last_err_addr  output  A  address of most recently accepted AW or AR
last_err_write  output  1  1 if last_err_addr came from AW, 0 if from AR
err_pulse  output  1  one-cycle pulse on any AW or AR acceptance

Behaviour:
- Reset (aresetn low at posedge aclk): all queues empty; awready=wready=arready=0 during reset cycle then follow rules below; bvalid=rvalid=0; counters=0; last_err_addr=0; last_err_write=0; err_pulse=0. Reset mid-transaction discards all queued entries; no response issued for them.
- Write address queue: FIFO of DEPTH entries {awid, awaddr}. awready = ~aw_full (registered-state based, no combinational dependence on awvalid). Push on awvalid&awready.
- Write data credit: counter w_cnt 0..DEPTH. wready = (w_cnt != DEPTH). Increment on wvalid&wready; wdata/wstrb ignored. AW and W may arrive in any order or same cycle.
- B generation: bvalid = aw_queue non-empty & w_cnt>0. bid = head awid; bresp = RESP. On bvalid&bready: pop AW head, decrement w_cnt. Simultaneous W accept and B pop leave w_cnt unchanged; simultaneous AW push/pop is legal when not full.
- Earliest B: bvalid in cycle after the later of AW/W handshakes (1-cycle latency). bvalid held with stable bid/bresp until bready.
- Read queue: FIFO of DEPTH arid entries. arready = ~ar_full. rvalid = ar_queue non-empty; rid = head arid; rdata = D; rresp = RESP; rlast = 1. Pop on rvalid&rready. Earliest rvalid cycle after AR handshake. No bypass: when full, arready=0 even if rready high same cycle.
- Back-to-back: with bready/rready held high, sustained throughput is one transaction per cycle per direction once DEPTH>=2.
- Counters: increment on respective response handshake; hold at all-ones (no wrap).
- last_err_addr/last_err_write: updated at AW or AR acceptance, registered (visible next cycle). Same-cycle AW and AR acceptance: AW wins (last_err_write=1). err_pulse = registered OR of both acceptances.
- Write and read paths fully independent; no ordering between them.

Test Plan:
- Single read: AR arid=1 addr 0x4000_0010, rready=1 -> rvalid cycle t+1, rdata=0xbaadc0de, rresp=2'b11, rid=1, rlast=1; rd_err_count=1; last_err_addr=0x4000_0010, last_err_write=0.
- W before AW: W at t, AW awid=0 at t+3 -> bvalid at t+4, bid=0, bresp=2'b11; wr_err_count=1.
- Backpressure: bready=0, issue 3 AW+W with DEPTH=2 -> awready=0 and wready=0 after 2 accepted; release bready -> 2 B's in order, then third accepted and answered; count=3.
- Simultaneous AW and AR accept same cycle addr 0x100 / 0x200 -> last_err_addr=0x100, last_err_write=1, err_pulse high one cycle.
- Saturation with CW=2: 5 reads -> rd_err_count sticks at 3.
- Reset with 2 reads queued and rready=0 -> rvalid=0 next cycle, arready=1, counters 0, no stale rid after reset.
